// File: rtl/fml_lfsr_check_if.sv
// FML port bundle between the LFSR pattern checker (master) and ddr_ctrl (slave).
interface fml_lfsr_check_if #(
  parameter int adr_width = 25,
  parameter int dat_width = 32,
  parameter int msk_width = 4
);
  logic                 fml_wr;
  logic                 fml_rd;
  logic                 fml_done;
  logic [adr_width-1:0] fml_adr;
  logic [dat_width-1:0] fml_wdata;
  logic [msk_width-1:0] fml_msk;
  logic [dat_width-1:0] fml_rdata;

  modport master (
    output fml_wr, fml_rd, fml_adr, fml_wdata, fml_msk,
    input  fml_done, fml_rdata
  );

  modport slave (
    input  fml_wr, fml_rd, fml_adr, fml_wdata, fml_msk,
    output fml_done, fml_rdata
  );
endinterface

// File: rtl/fml_lfsr_check.sv
// FML master that writes a Galois LFSR pattern over a word range, reads it back and
// reports pass/fail, a saturating mismatch count and the first failing address.
module fml_lfsr_check #(
  parameter int                   adr_width = 25,
  parameter int                   dat_width = 32,
  parameter int                   msk_width = 4,
  parameter int                   words     = 1024,
  parameter int                   adr_step  = 4,
  parameter logic [dat_width-1:0] seed      = 'h1,
  parameter int                   err_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 loop,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [err_width-1:0] err_cnt,
  output logic [adr_width-1:0] first_err_adr,
  output logic [7:0]           led,
  fml_lfsr_check_if.master     fml
);

  localparam int                   idx_width = $clog2(words + 1);
  localparam logic [idx_width-1:0] last_idx  = idx_width'(words);
  localparam logic [dat_width-1:0] taps      = 'h0040_0007;

  typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, DONE} state_t;

  state_t               state, state_n;
  logic [idx_width-1:0] idx, idx_n;
  logic [dat_width-1:0] lfsr, lfsr_n;
  logic [dat_width-1:0] pass_seed, pass_seed_n;
  logic [4:0]           pass_cnt;
  logic                 clr_stats;
  logic                 chk;
  logic                 pass_inc;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  function automatic logic [dat_width-1:0] lfsr_next(input logic [dat_width-1:0] l);
    return {l[dat_width-2:0], 1'b0} ^ (l[dat_width-1] ? taps : '0);
  endfunction

  function automatic logic [err_width-1:0] sat_inc(input logic [err_width-1:0] c);
    return (&c) ? c : c + err_width'(1);
  endfunction

  function automatic logic [adr_width-1:0] adr_of(input logic [idx_width-1:0] i);
    return adr_width'(i) * adr_width'(adr_step);
  endfunction

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    lfsr_n      = lfsr;
    pass_seed_n = pass_seed;
    clr_stats   = 1'b0;
    chk         = 1'b0;
    pass_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = WR;
          idx_n       = '0;
          lfsr_n      = seed;
          pass_seed_n = seed;
          clr_stats   = 1'b1;
        end
      end
      WR: begin
        if (fml.fml_done) begin
          idx_n   = idx + idx_width'(1);
          lfsr_n  = lfsr_next(lfsr);
          state_n = WGAP;
        end
      end
      WGAP: begin
        if (idx == last_idx) begin
          idx_n   = '0;
          lfsr_n  = pass_seed;
          state_n = RD;
        end else begin
          state_n = WR;
        end
      end
      RD: begin
        if (fml.fml_done) begin
          chk     = 1'b1;
          idx_n   = idx + idx_width'(1);
          lfsr_n  = lfsr_next(lfsr);
          state_n = RGAP;
        end
      end
      RGAP: begin
        if (idx == last_idx) begin
          pass_inc = 1'b1;
          if (loop) begin
            // next pass continues the sequence where this one stopped
            pass_seed_n = lfsr;
            idx_n       = '0;
            state_n     = WR;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    idx       <= idx_n;
    lfsr      <= lfsr_n;
    pass_seed <= pass_seed_n;
  end

  // request, address and data are registered from the next state so they stay
  // stable for the whole access and drop straight away on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fml.fml_wr    <= 1'b0;
      fml.fml_rd    <= 1'b0;
      fml.fml_adr   <= '0;
      fml.fml_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_adr <= '0;
      pass_cnt      <= '0;
    end else begin
      state      <= state_n;
      fml.fml_wr <= (state_n == WR);
      fml.fml_rd <= (state_n == RD);
      busy       <= (state_n inside {WR, WGAP, RD, RGAP});
      if (state_n == WR || state_n == RD)
        fml.fml_adr <= adr_of(idx_n);
      if (state_n == WR)
        fml.fml_wdata <= lfsr_n;
      if (clr_stats) begin
        err_cnt       <= '0;
        done          <= 1'b0;
        pass          <= 1'b0;
        first_err_adr <= '0;
      end
      if (chk && (fml.fml_rdata != lfsr)) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0)
          first_err_adr <= fml.fml_adr;
      end
      if (pass_inc)
        pass_cnt <= pass_cnt + 5'd1;
      if (state_n == DONE) begin
        done <= 1'b1;
        pass <= (err_cnt == '0);
      end
    end
  end

  assign fml.fml_msk = {msk_width{1'b0}};
  assign led         = {pass & done, busy, |err_cnt, pass_cnt};

endmodule
